// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Definitions shared by the rotary-encoder input conditioner and the
// encoder/position-counter stage that consumes its outputs.
//   ENC_IDLE_LEVEL : level of an idle encoder pin (pins are pulled up)
//   edge_t         : packed pair of one-cycle edge strobes for one channel
// ---------------------------------------------------------------------------
package encoder_pkg;

   localparam logic ENC_IDLE_LEVEL = 1'b1;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_t;

endpackage : encoder_pkg

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One encoder pin: SYNC_STAGES-flop synchronizer into the CLOCK domain,
// followed by a consecutive-cycle debounce filter. A new level is accepted
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement with the
// current clean level; any agreeing cycle restarts the window.
// Ports:
//   CLOCK   in  system clock, rising edge
//   RESET_n in  asynchronous active-low reset
//   raw     in  raw asynchronous pin level
//   clean   out debounced level (resets to the idle level)
//   rise    out one-cycle strobe, clean 0->1 (registered)
//   fall    out one-cycle strobe, clean 1->0 (registered)
// ---------------------------------------------------------------------------
module debounce_channel
   import encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic CLOCK,
   input  logic RESET_n,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_channel: SYNC_STAGES must be >= 2");
   end

   // Guarded so a bad parameter reports the error above instead of a
   // zero-width vector.
   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   edge_t                  edge_q, edge_d;
   logic                   s;

   // Last synchronizer stage; the only point where the pin enters logic.
   assign s = sync_q[SYNC_STAGES-1];

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
      cnt_d   = '0;
      clean_d = clean_q;
      edge_d  = '0;
      if (s != clean_q) begin
         if (cnt_q == CNT_LAST) begin
            // Window complete: accept the new level and strobe with it.
            clean_d     = s;
            edge_d.rise = s;
            edge_d.fall = ~s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLOCK or negedge RESET_n) begin
      if (!RESET_n) begin
         sync_q  <= {SYNC_STAGES{ENC_IDLE_LEVEL}};
         cnt_q   <= '0;
         clean_q <= ENC_IDLE_LEVEL;
         edge_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         edge_q  <= edge_d;
      end
   end

   assign clean = clean_q;
   assign rise  = edge_q.rise;
   assign fall  = edge_q.fall;

endmodule : debounce_channel

// File: rtl/quad_input_conditioner.sv
// ---------------------------------------------------------------------------
// quad_input_conditioner
// Cleans the two raw rotary-encoder pins (DT, CLK) for the quadrature
// counter: per-channel synchronizer + debounce, clean levels, edge strobes,
// and a quadrature-error strobe when both channels change in one cycle.
// Ports:
//   CLOCK     in  system clock, rising edge
//   RESET_n   in  asynchronous active-low reset
//   DT, CLK   in  raw encoder pins (CLK is data, not a clock)
//   dt_clean, clk_clean            out debounced levels
//   dt_rise, dt_fall, clk_rise, clk_fall  out one-cycle edge strobes
//   quad_err  out one-cycle strobe: both clean levels changed together
// ---------------------------------------------------------------------------
module quad_input_conditioner
   import encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic CLOCK,
   input  logic RESET_n,
   input  logic DT,
   input  logic CLK,
   output logic dt_clean,
   output logic clk_clean,
   output logic dt_rise,
   output logic dt_fall,
   output logic clk_rise,
   output logic clk_fall,
   output logic quad_err
);

   edge_t dt_edge;
   edge_t clk_edge;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_dt (
      .CLOCK   (CLOCK),
      .RESET_n (RESET_n),
      .raw     (DT),
      .clean   (dt_clean),
      .rise    (dt_edge.rise),
      .fall    (dt_edge.fall)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_clk (
      .CLOCK   (CLOCK),
      .RESET_n (RESET_n),
      .raw     (CLK),
      .clean   (clk_clean),
      .rise    (clk_edge.rise),
      .fall    (clk_edge.fall)
   );

   assign dt_rise  = dt_edge.rise;
   assign dt_fall  = dt_edge.fall;
   assign clk_rise = clk_edge.rise;
   assign clk_fall = clk_edge.fall;

   // Built from registered strobes, so it is aligned with them and glitch-free
   // at the clock edge. Valid quadrature never moves both channels at once.
   assign quad_err = (dt_edge.rise | dt_edge.fall) & (clk_edge.rise | clk_edge.fall);

endmodule : quad_input_conditioner

// File: tb/tb_quad_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_quad_input_conditioner
// Self-checking bench for quad_input_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2. Pins are driven just after a falling edge; a clean step
// driven when the bench cycle count is c must produce its strobe on the
// rising edge that makes the count c+6. Expected strobe events go into a
// queue when the stimulus is driven; a monitor pops and compares them
// whenever any strobe is seen, and any strobe with nothing queued is an error.
// ---------------------------------------------------------------------------
module tb_quad_input_conditioner;

   localparam int DEB   = 4;
   localparam int SYNC  = 2;
   localparam int LAT   = DEB + SYNC;

   typedef struct {
      int         cyc;
      logic [4:0] strb;   // {dt_rise, dt_fall, clk_rise, clk_fall, quad_err}
      logic [1:0] lvl;    // {dt_clean, clk_clean} after the change
   } exp_t;

   logic clk;
   logic rst_n;
   logic dt_pin;
   logic clk_pin;
   logic dt_clean, clk_clean;
   logic dt_rise, dt_fall, clk_rise, clk_fall, quad_err;

   int   cyc;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   quad_input_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .CLOCK     (clk),
      .RESET_n   (rst_n),
      .DT        (dt_pin),
      .CLK       (clk_pin),
      .dt_clean  (dt_clean),
      .clk_clean (clk_clean),
      .dt_rise   (dt_rise),
      .dt_fall   (dt_fall),
      .clk_rise  (clk_rise),
      .clk_fall  (clk_fall),
      .quad_err  (quad_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Strobe monitor: outputs only move on the rising edge, so sample on the falling one.
   always @(negedge clk) begin
      logic [4:0] strb;
      exp_t       e;
      strb = {dt_rise, dt_fall, clk_rise, clk_fall, quad_err};
      if (strb != 5'b0) begin
         if (sb.size() == 0) begin
            check("spurious_strobe", 32'(strb), 32'h0);
         end else begin
            e = sb.pop_front();
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            check("strobe_vec", 32'(strb), 32'(e.strb));
            check("strobe_lvl", 32'({dt_clean, clk_clean}), 32'(e.lvl));
         end
      end
   end

   // Called right after a falling edge at which a change was queued with
   // expected cycle cyc+LAT: the levels must hold one cycle short of the
   // latency, change exactly at it, and the queue must drain.
   task automatic run_window(input string tag, input logic [1:0] old_lvl, input logic [1:0] new_lvl);
      repeat (LAT - 1) @(negedge clk);
      check({tag, "_hold"}, 32'({dt_clean, clk_clean}), 32'(old_lvl));
      @(negedge clk);
      check({tag, "_new"}, 32'({dt_clean, clk_clean}), 32'(new_lvl));
      repeat (4) @(negedge clk);
      check({tag, "_drain"}, 32'(sb.size()), 32'h0);
   endtask

   // Drive a clean step on both pins and queue the strobe vector it implies.
   task automatic step_pins(input string tag, input logic n_dt, input logic n_clk);
      logic [1:0] old_lvl;
      exp_t       e;
      old_lvl = {dt_pin, clk_pin};
      e.cyc   = cyc + LAT;
      e.lvl   = {n_dt, n_clk};
      e.strb  = {~dt_pin & n_dt, dt_pin & ~n_dt, ~clk_pin & n_clk, clk_pin & ~n_clk,
                 (dt_pin != n_dt) && (clk_pin != n_clk)};
      dt_pin  = n_dt;
      clk_pin = n_clk;
      if (e.strb != 5'b0) sb.push_back(e);
      run_window(tag, old_lvl, {n_dt, n_clk});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      dt_pin   = 1'b1;
      clk_pin  = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_levels", 32'({dt_clean, clk_clean}), 32'h3);
      check("rst_strobes", 32'({dt_rise, dt_fall, clk_rise, clk_fall, quad_err}), 32'h0);
      rst_n = 1'b1;

      // 1: idle pins for 20 cycles, nothing moves.
      for (int i = 0; i < 4; i++) begin
         repeat (5) @(negedge clk);
         check("t1_idle", 32'({dt_clean, clk_clean}), 32'h3);
      end

      // 2: single clean DT fall, then back up.
      step_pins("t2_dt_fall", 1'b0, 1'b1);
      step_pins("t2_dt_rise", 1'b1, 1'b1);

      // 3: DT bounces in 2-cycle pieces, never long enough to be accepted.
      for (int i = 0; i < 4; i++) begin
         dt_pin = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) @(negedge clk);
         check("t3_bounce", 32'(dt_clean), 32'h1);
      end
      step_pins("t3_hold", 1'b0, 1'b1);
      step_pins("t3_restore", 1'b1, 1'b1);

      // 4: both pins change on the same edge.
      step_pins("t4_both_fall", 1'b0, 1'b0);
      step_pins("t4_both_rise", 1'b1, 1'b1);

      // 5: clockwise detent, 10 cycles between steps.
      step_pins("t5_clk_fall", 1'b1, 1'b0);
      step_pins("t5_dt_fall", 1'b0, 1'b0);
      step_pins("t5_clk_rise", 1'b0, 1'b1);
      step_pins("t5_dt_rise", 1'b1, 1'b1);

      // 6: reset pulse mid-count discards the count; counting restarts.
      dt_pin = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_pre_rst", 32'(dt_clean), 32'h1);
      #1 rst_n = 1'b0;
      #1 check("t6_in_rst", 32'(dt_clean), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      e.cyc = cyc + LAT; e.strb = 5'b01000; e.lvl = 2'b01;
      sb.push_back(e);
      run_window("t6_restart", 2'b11, 2'b01);

      // 6b: reset while dt_clean is low forces it high without a clock edge.
      #1 rst_n = 1'b0;
      #1 check("t6b_async", 32'(dt_clean), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      e.cyc = cyc + LAT; e.strb = 5'b01000; e.lvl = 2'b01;
      sb.push_back(e);
      run_window("t6b_restart", 2'b11, 2'b01);
      step_pins("t6b_restore", 1'b1, 1'b1);

      repeat (5) @(negedge clk);
      check("final_drain", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_quad_input_conditioner
